hazard_ctrl: RTL



---
 rtl/hazard_pkg.sv | 24 ++
 rtl/hazard_ctrl_sat_counter.sv | 33 +++
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // One scoreboard entry: a destination register still in flight.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } slot_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Pipeline control mode, decoded into the enable/flush outputs.
    typedef enum logic [1:0] {
        NORMAL,
        STALL,
        FLUSH
    } ctrl_mode_e;

    // A source matches a slot only if the slot holds a live write to that register.
    function automatic logic slot_match(input slot_t slot, input logic [4:0] rs);
        return slot.valid && (slot.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count up on each event, sticking at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (i_inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for a non-forwarding 5-stage RV32I pipeline. Tracks
// destination registers in EX/MEM/WB and stalls ID on a RAW dependency;
// flushes IF/ID and ID/EX on a taken branch resolved in EX.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned WB_BYPASS = 1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_id_rd_addr,
    input  logic             i_id_rd_wren,
    input  logic             i_ex_br_taken,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_stall,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam bit WbHazard = (WB_BYPASS == 0);

    slot_t      ex_q, ex_d;
    slot_t      mem_q, mem_d;
    slot_t      wb_q, wb_d;
    logic       src1_haz;
    logic       src2_haz;
    logic       hazard;
    logic       flush;
    logic       stall;
    ctrl_mode_e mode;

    // RAW detection of the ID sources against the in-flight destinations.
    always_comb begin
        src1_haz = i_id_valid && i_id_rs1_used && (i_id_rs1_addr != REG_X0) &&
                   (slot_match(ex_q, i_id_rs1_addr) || slot_match(mem_q, i_id_rs1_addr) ||
                    (WbHazard && slot_match(wb_q, i_id_rs1_addr)));
        src2_haz = i_id_valid && i_id_rs2_used && (i_id_rs2_addr != REG_X0) &&
                   (slot_match(ex_q, i_id_rs2_addr) || slot_match(mem_q, i_id_rs2_addr) ||
                    (WbHazard && slot_match(wb_q, i_id_rs2_addr)));
        hazard   = src1_haz || src2_haz;
    end

    // Mode select: reset forces Normal, a taken branch beats a stall because it
    // kills the stalled ID instruction anyway.
    always_comb begin
        mode = NORMAL;
        if (i_reset) begin
            mode = NORMAL;
        end else if (i_ex_br_taken) begin
            mode = FLUSH;
        end else if (hazard) begin
            mode = STALL;
        end
        flush = (mode == FLUSH);
        stall = (mode == STALL);
    end

    // Output decode from the control mode.
    always_comb begin
        o_pc_en      = 1'b1;
        o_ifid_en    = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_stall      = 1'b0;
        unique case (mode)
            STALL: begin
                o_pc_en      = 1'b0;
                o_ifid_en    = 1'b0;
                o_idex_flush = 1'b1;
                o_stall      = 1'b1;
            end
            FLUSH: begin
                o_ifid_flush = 1'b1;
                o_idex_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // Scoreboard next state: a bubble enters EX on stall/flush/empty ID.
    always_comb begin
        ex_d = '0;
        if (!(stall || flush || !i_id_valid)) begin
            ex_d.valid = i_id_rd_wren && (i_id_rd_addr != REG_X0);
            ex_d.rd    = i_id_rd_addr;
        end
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    // Scoreboard registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_inc  (stall),
        .o_cnt  (o_stall_cnt)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_inc  (flush),
        .o_cnt  (o_flush_cnt)
    );

endmodule
